// File: rtl/sys_array_ctrl_pkg.sv
// Shared types and constants for the 2x2 bfloat16 systolic array sequencer.
// Element slices address the row-major packed operand words.
package sys_array_ctrl_pkg;
  localparam int BF16_W   = 16;
  localparam int FEED_LEN = 3;

  localparam int A00_LSB = 0;
  localparam int A01_LSB = 16;
  localparam int A10_LSB = 32;
  localparam int A11_LSB = 48;
  localparam int B00_LSB = 0;
  localparam int B01_LSB = 16;
  localparam int B10_LSB = 32;
  localparam int B11_LSB = 48;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FEED,
    DRAIN,
    OUT
  } state_t;
endpackage

// File: rtl/sys_array_skew_feeder.sv
// Maps a feed step (0..2) plus the held operands onto the skewed row/column buses.
// Purely combinational; every bus is zero when not enabled or not scheduled.
module sys_array_skew_feeder
  import sys_array_ctrl_pkg::*;
(
  input  logic              en,
  input  logic [1:0]        step,
  input  logic [63:0]       a_flat,
  input  logic [63:0]       b_flat,
  output logic [BF16_W-1:0] row0,
  output logic [BF16_W-1:0] row1,
  output logic [BF16_W-1:0] col0,
  output logic [BF16_W-1:0] col1
);
  always_comb begin
    row0 = '0;
    row1 = '0;
    col0 = '0;
    col1 = '0;
    if (en) begin
      // Row i / column j start one step late per index to form the wavefront.
      case (step)
        2'd0: begin
          row0 = a_flat[A00_LSB +: BF16_W];
          col0 = b_flat[B00_LSB +: BF16_W];
        end
        2'd1: begin
          row0 = a_flat[A01_LSB +: BF16_W];
          col0 = b_flat[B10_LSB +: BF16_W];
          row1 = a_flat[A10_LSB +: BF16_W];
          col1 = b_flat[B01_LSB +: BF16_W];
        end
        2'd2: begin
          row1 = a_flat[A11_LSB +: BF16_W];
          col1 = b_flat[B11_LSB +: BF16_W];
        end
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/sys_array_ctrl_bfloat_16.sv
// Sequencer for the 2x2 bfloat16 systolic array: accept A/B, clear, skew-feed, wait for
// done (with timeout), then hold C on a valid/ready output until consumed.
module sys_array_ctrl_bfloat_16
  import sys_array_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CLR_CYCLES     = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [63:0]       a_flat,
  input  logic [63:0]       b_flat,
  output logic              arr_rst,
  output logic              arr_load_in,
  output logic [BF16_W-1:0] arr_row0,
  output logic [BF16_W-1:0] arr_row1,
  output logic [BF16_W-1:0] arr_col0,
  output logic [BF16_W-1:0] arr_col1,
  input  logic [BF16_W-1:0] arr_c00,
  input  logic [BF16_W-1:0] arr_c01,
  input  logic [BF16_W-1:0] arr_c10,
  input  logic [BF16_W-1:0] arr_c11,
  input  logic              arr_done,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [63:0]       c_flat,
  output logic              busy,
  output logic              timeout_err
);
  localparam int DW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int CW = $clog2(CLR_CYCLES + 1);

  state_t        state, state_nxt;
  logic [63:0]   a_reg, b_reg, c_reg;
  logic [CW-1:0] clr_cnt;
  logic [1:0]    feed_idx;
  logic [DW-1:0] drain_cnt;
  logic          timeout_q;
  logic          clr_last, feed_last, drain_last;

  assign clr_last   = (clr_cnt == CW'(CLR_CYCLES - 1));
  assign feed_last  = (feed_idx == 2'(FEED_LEN - 1));
  assign drain_last = (drain_cnt == DW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      c_reg     <= '0;
      clr_cnt   <= '0;
      feed_idx  <= '0;
      drain_cnt <= '0;
      timeout_q <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          clr_cnt  <= '0;
          feed_idx <= '0;
          if (in_valid) begin
            a_reg <= a_flat;
            b_reg <= b_flat;
          end
        end
        CLEAR: clr_cnt <= clr_cnt + 1'b1;
        FEED: begin
          feed_idx  <= feed_idx + 1'b1;
          drain_cnt <= '0;
        end
        DRAIN: begin
          drain_cnt <= drain_cnt + 1'b1;
          if (arr_done) begin
            c_reg <= {arr_c11, arr_c10, arr_c01, arr_c00};
          end else if (drain_last) begin
            timeout_q <= 1'b1;
            c_reg     <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs are forced to their reset values combinationally while rst is high.
  always_comb begin
    state_nxt   = state;
    in_ready    = 1'b0;
    busy        = 1'b0;
    out_valid   = 1'b0;
    arr_rst     = rst;
    arr_load_in = 1'b0;
    case (state)
      IDLE: begin
        in_ready = ~rst;
        if (in_valid) state_nxt = CLEAR;
      end
      CLEAR: begin
        arr_rst = 1'b1;
        if (clr_last) state_nxt = FEED;
      end
      FEED: begin
        arr_load_in = ~rst;
        if (feed_last) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (arr_done) state_nxt = OUT;
        else if (drain_last) state_nxt = IDLE;
      end
      OUT: begin
        out_valid = ~rst;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (state != IDLE) busy = ~rst;
  end

  assign c_flat      = rst ? 64'h0 : c_reg;
  assign timeout_err = timeout_q & ~rst;

  sys_array_skew_feeder u_feeder (
    .en     (arr_load_in),
    .step   (feed_idx),
    .a_flat (a_reg),
    .b_flat (b_reg),
    .row0   (arr_row0),
    .row1   (arr_row1),
    .col0   (arr_col0),
    .col1   (arr_col1)
  );
endmodule
